// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: stall bit positions and tracker entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_hazard_ctrl_pkg;

  // Bit positions inside the stall vector; slot k freezes at STALL_SLOT_BASE + k.
  localparam int STALL_PC        = 0;
  localparam int STALL_IF        = 1;
  localparam int STALL_ID        = 2;
  localparam int STALL_SLOT_BASE = 3;

  // Destination field is sized for the widest register index we support (REG_AW <= 8).
  localparam int TRK_DST_W = 8;

  typedef struct packed {
    logic                 valid;
    logic                 we;
    logic                 load;
    logic [TRK_DST_W-1:0] dst;
  } trk_entry_t;

  localparam trk_entry_t TRK_EMPTY = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage hazard query bundle: instruction fields in, stall/forward controls out.
// Latency: n/a (wires only).
// Backpressure: stall is the backpressure; the master must hold ID while stall[2] is set.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW    = 5,
  parameter int NSRC      = 2,
  parameter int FWD_DEPTH = 3
);
  localparam int SEL_W = $clog2(FWD_DEPTH + 1);

  logic                     id_valid;
  logic [NSRC*REG_AW-1:0]   id_src;
  logic [NSRC-1:0]          id_src_en;
  logic [REG_AW-1:0]        id_dst;
  logic                     id_we;
  logic                     id_is_load;
  logic                     ex_busy_req;
  logic                     flush;
  logic [FWD_DEPTH+2:0]     stall;
  logic [NSRC*SEL_W-1:0]    fwd_sel;

  modport master (
    output id_valid, id_src, id_src_en, id_dst, id_we, id_is_load, ex_busy_req, flush,
    input  stall, fwd_sel
  );

  modport slave (
    input  id_valid, id_src, id_src_en, id_dst, id_we, id_is_load, ex_busy_req, flush,
    output stall, fwd_sel
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_slot.sv
// One tracker entry shadowing a post-ID pipeline stage (load / hold / bubble).
// Latency: 1 cycle from upstream entry to this entry.
// Backpressure: holds while its own stall bit is set; inserts a bubble when only upstream is stalled.
module hazard_slot
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush_i,
  input  logic       stall_up_i,
  input  logic       stall_self_i,
  input  trk_entry_t ent_i,
  output trk_entry_t ent_o
);

  trk_entry_t ent_q, ent_d;

  // Next entry: flush beats everything; a frozen stage keeps its contents; a frozen
  // upstream feeding a moving stage leaves a bubble behind.
  always_comb begin
    ent_d = ent_q;
    if (flush_i) begin
      ent_d = TRK_EMPTY;
    end else if (stall_self_i) begin
      ent_d = ent_q;
    end else if (stall_up_i) begin
      ent_d = TRK_EMPTY;
    end else begin
      ent_d = ent_i;
    end
  end

  // Entry register with synchronous reset to an empty slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q <= TRK_EMPTY;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign ent_o = ent_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// In-order pipeline hazard control: per-source forwarding select plus load-use / EX-busy stalls.
// Latency: stall and fwd_sel are combinational from ID inputs and the tracker; tracker advances each edge.
// Backpressure: ex_busy_req freezes PC..slot0, load-use freezes PC..ID; flush squashes and forces stall low.
// Optional HAZARD_PERF_EN adds saturating 32-bit load-use / busy stall cycle counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW         = 5,
  parameter int NSRC           = 2,
  parameter int FWD_DEPTH      = 3,
  parameter int LOAD_USE_DEPTH = 1
) (
  input  logic                clk,
  input  logic                rst,
`ifdef HAZARD_PERF_EN
  output logic [31:0]         lu_stall_cnt,
  output logic [31:0]         busy_stall_cnt,
`endif
  pipe_hazard_ctrl_if.slave   hz
);

  localparam int SEL_W   = $clog2(FWD_DEPTH + 1);
  localparam int STALL_W = FWD_DEPTH + 3;

  trk_entry_t               slot_q  [FWD_DEPTH];
  trk_entry_t               slot_in [FWD_DEPTH];
  logic [FWD_DEPTH-1:0]     match   [NSRC];
  logic [NSRC-1:0]          src_lu;
  logic                     lu_hit;
  logic                     front_frz;
  logic [STALL_W-1:0]       stall;
  logic [NSRC*SEL_W-1:0]    fwd_sel;

  // A source hits a slot when that slot will write the same non-zero register.
  always_comb begin
    match = '{default: '0};
    for (int i = 0; i < NSRC; i++) begin
      for (int k = 0; k < FWD_DEPTH; k++) begin
        match[i][k] = hz.id_valid && hz.id_src_en[i] &&
                      slot_q[k].valid && slot_q[k].we &&
                      (slot_q[k].dst == TRK_DST_W'(hz.id_src[i*REG_AW +: REG_AW])) &&
                      (hz.id_src[i*REG_AW +: REG_AW] != '0);
      end
    end
  end

  // Youngest hit wins: scan oldest to youngest so the lowest slot overwrites last.
  // A youngest hit on a load still inside the load-use window cannot be forwarded.
  always_comb begin
    fwd_sel = '0;
    src_lu  = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if (match[i][k]) begin
          fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
          src_lu[i]                 = slot_q[k].load && (k < LOAD_USE_DEPTH);
        end
      end
    end
  end

  assign lu_hit = |src_lu;

  // Stall vector: EX busy freezes the front end plus slot0 (superset of load-use);
  // flush squashes everything so nothing needs to be held that cycle.
  always_comb begin
    stall                  = '0;
    front_frz              = !hz.flush && (hz.ex_busy_req || lu_hit);
    stall[STALL_PC]        = front_frz;
    stall[STALL_IF]        = front_frz;
    stall[STALL_ID]        = front_frz;
    stall[STALL_SLOT_BASE] = !hz.flush && hz.ex_busy_req;
  end

  // Slot 0 is fed from the ID fields, every other slot from its predecessor.
  always_comb begin
    slot_in[0]       = TRK_EMPTY;
    slot_in[0].valid = hz.id_valid;
    slot_in[0].we    = hz.id_we;
    slot_in[0].load  = hz.id_is_load;
    slot_in[0].dst   = TRK_DST_W'(hz.id_dst);
    for (int k = 1; k < FWD_DEPTH; k++) begin
      slot_in[k] = slot_q[k-1];
    end
  end

  // The upstream stall bit of slot k sits directly below its own (ID for slot 0).
  for (genvar k = 0; k < FWD_DEPTH; k++) begin : g_slot
    hazard_slot u_slot (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (hz.flush),
      .stall_up_i   (stall[STALL_SLOT_BASE + k - 1]),
      .stall_self_i (stall[STALL_SLOT_BASE + k]),
      .ent_i        (slot_in[k]),
      .ent_o        (slot_q[k])
    );
  end

  assign hz.stall   = stall;
  assign hz.fwd_sel = fwd_sel;

`ifdef HAZARD_PERF_EN
  logic [31:0] lu_cnt_q, lu_cnt_d;
  logic [31:0] busy_cnt_q, busy_cnt_d;

  // Count cycles by stall cause; busy dominates so a cycle lands in only one counter.
  always_comb begin
    lu_cnt_d   = lu_cnt_q;
    busy_cnt_d = busy_cnt_q;
    if (!hz.flush && hz.ex_busy_req && (busy_cnt_q != '1)) begin
      busy_cnt_d = busy_cnt_q + 32'd1;
    end
    if (!hz.flush && !hz.ex_busy_req && lu_hit && (lu_cnt_q != '1)) begin
      lu_cnt_d = lu_cnt_q + 32'd1;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt_q   <= '0;
      busy_cnt_q <= '0;
    end else begin
      lu_cnt_q   <= lu_cnt_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign lu_stall_cnt   = lu_cnt_q;
  assign busy_stall_cnt = busy_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl (default parameters; HAZARD_PERF_EN optional).
// Each vector is one cycle: inputs driven after the falling edge, outputs checked 1 time unit later.
// Tracker state is built up by earlier vectors in the table, so order matters.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic rst;
`ifdef HAZARD_PERF_EN
  logic [31:0] lu_stall_cnt;
  logic [31:0] busy_stall_cnt;
`endif

  pipe_hazard_ctrl_if #(.REG_AW(5), .NSRC(2), .FWD_DEPTH(3)) hz_if ();

  pipe_hazard_ctrl #(
    .REG_AW(5), .NSRC(2), .FWD_DEPTH(3), .LOAD_USE_DEPTH(1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef HAZARD_PERF_EN
    .lu_stall_cnt   (lu_stall_cnt),
    .busy_stall_cnt (busy_stall_cnt),
`endif
    .hz             (hz_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       v;
    logic [4:0] s0;
    logic [4:0] s1;
    logic [1:0] en;
    logic [4:0] dst;
    logic       we;
    logic       ld;
    logic       busy;
    logic       fl;
    logic [5:0] est;
    logic [1:0] ef0;
    logic [1:0] ef1;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input int r, input int v, input int s0, input int s1,
                              input int en, input int dst, input int we, input int ld,
                              input int bz, input int fl, input int est,
                              input int ef0, input int ef1);
    vec_t t;
    t.rst  = r[0];
    t.v    = v[0];
    t.s0   = s0[4:0];
    t.s1   = s1[4:0];
    t.en   = en[1:0];
    t.dst  = dst[4:0];
    t.we   = we[0];
    t.ld   = ld[0];
    t.busy = bz[0];
    t.fl   = fl[0];
    t.est  = est[5:0];
    t.ef0  = ef0[1:0];
    t.ef1  = ef1[1:0];
    return t;
  endfunction

  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    rst                  = t.rst;
    hz_if.id_valid       = t.v;
    hz_if.id_src         = {t.s1, t.s0};
    hz_if.id_src_en      = t.en;
    hz_if.id_dst         = t.dst;
    hz_if.id_we          = t.we;
    hz_if.id_is_load     = t.ld;
    hz_if.ex_busy_req    = t.busy;
    hz_if.flush          = t.fl;
    #1;
    n_vec++;
    if (hz_if.stall !== t.est) begin
      n_bad++;
      $display("FAIL %s stall: got %b want %b", tag, hz_if.stall, t.est);
    end
    if (hz_if.fwd_sel !== {t.ef1, t.ef0}) begin
      n_bad++;
      $display("FAIL %s fwd_sel: got %b want %b", tag, hz_if.fwd_sel, {t.ef1, t.ef0});
    end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic chk_cnt(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask
`endif

  initial begin
    rst               = 1'b1;
    hz_if.id_valid    = 1'b0;
    hz_if.id_src      = '0;
    hz_if.id_src_en   = '0;
    hz_if.id_dst      = '0;
    hz_if.id_we       = 1'b0;
    hz_if.id_is_load  = 1'b0;
    hz_if.ex_busy_req = 1'b0;
    hz_if.flush       = 1'b0;

    //            rst v  s0 s1 en     dst we ld bz fl  stall      f0 f1
    // reset: empty tracker, idle ID
    tbl.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 6'b000000, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 6'b000000, 0, 0));
    // writer of r8 walks EX -> MEM -> WB
    tbl.push_back(mk(0, 1, 0, 0, 2'b00, 8, 1, 0, 0, 0, 6'b000000, 0, 0));
    tbl.push_back(mk(0, 1, 8, 0, 2'b01, 3, 0, 0, 0, 0, 6'b000000, 1, 0));
    tbl.push_back(mk(0, 1, 8, 8, 2'b11, 3, 0, 0, 0, 0, 6'b000000, 2, 2));
    tbl.push_back(mk(0, 1, 8, 0, 2'b01, 3, 0, 0, 0, 0, 6'b000000, 3, 0));
    // r4 in slot0 and slot2, r5 in slot1: youngest wins
    tbl.push_back(mk(0, 1, 0, 0, 2'b00, 4, 1, 0, 0, 0, 6'b000000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b00, 5, 1, 0, 0, 0, 6'b000000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b00, 4, 1, 0, 0, 0, 6'b000000, 0, 0));
    tbl.push_back(mk(0, 1, 4, 5, 2'b11, 0, 0, 0, 0, 0, 6'b000000, 1, 2));
    // r0 never forwards even with a writer of r0 in flight
    tbl.push_back(mk(0, 1, 0, 0, 2'b00, 0, 1, 0, 0, 0, 6'b000000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4, 2'b11, 0, 0, 0, 0, 0, 6'b000000, 0, 3));
    // disabled source and invalid ID never forward
    tbl.push_back(mk(0, 1, 0, 0, 2'b00, 7, 1, 0, 0, 0, 6'b000000, 0, 0));
    tbl.push_back(mk(0, 1, 7, 7, 2'b10, 0, 0, 0, 0, 0, 6'b000000, 0, 1));
    tbl.push_back(mk(0, 0, 7, 7, 2'b11, 0, 0, 0, 0, 0, 6'b000000, 0, 0));
    // load r9 then immediate use: one load-use stall, then forward from MEM
    tbl.push_back(mk(0, 1, 0, 0, 2'b00, 9, 1, 1, 0, 0, 6'b000000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 9, 2'b10, 2, 1, 0, 0, 0, 6'b000111, 0, 1));
    tbl.push_back(mk(0, 1, 0, 9, 2'b10, 2, 1, 0, 0, 0, 6'b000000, 0, 2));
    // load r6 in slot0, r2 in slot1; EX busy 4 cycles with load-use pending
    tbl.push_back(mk(0, 1, 0, 0, 2'b00, 6, 1, 1, 0, 0, 6'b000000, 0, 0));
    tbl.push_back(mk(0, 1, 6, 2, 2'b11, 1, 1, 0, 1, 0, 6'b001111, 1, 2));
    tbl.push_back(mk(0, 1, 6, 2, 2'b11, 1, 1, 0, 1, 0, 6'b001111, 1, 3));
    tbl.push_back(mk(0, 1, 6, 2, 2'b11, 1, 1, 0, 1, 0, 6'b001111, 1, 0));
    tbl.push_back(mk(0, 1, 6, 2, 2'b11, 1, 1, 0, 1, 0, 6'b001111, 1, 0));
    tbl.push_back(mk(0, 1, 6, 2, 2'b11, 1, 1, 0, 0, 0, 6'b000111, 1, 0));
    tbl.push_back(mk(0, 1, 6, 2, 2'b11, 1, 1, 0, 0, 0, 6'b000000, 2, 0));
    // fill tracker with r10/r11/r1, flush, then nothing forwards
    tbl.push_back(mk(0, 1, 0, 0, 2'b00, 10, 1, 0, 0, 0, 6'b000000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2'b00, 11, 1, 0, 0, 0, 6'b000000, 0, 0));
    tbl.push_back(mk(0, 1, 11, 1, 2'b11, 12, 1, 0, 0, 1, 6'b000000, 1, 3));
    tbl.push_back(mk(0, 1, 11, 1, 2'b11, 0, 0, 0, 0, 0, 6'b000000, 0, 0));
    // flush overrides a busy stall and clears a pending load
    tbl.push_back(mk(0, 1, 0, 0, 2'b00, 9, 1, 1, 0, 0, 6'b000000, 0, 0));
    tbl.push_back(mk(0, 1, 9, 0, 2'b01, 0, 0, 0, 1, 1, 6'b000000, 1, 0));
    tbl.push_back(mk(0, 1, 9, 0, 2'b01, 0, 0, 0, 0, 0, 6'b000000, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // reset in the middle of a stall: stall drops the cycle after reset
    apply(mk(0, 1, 0, 0, 2'b00, 9, 1, 1, 0, 0, 6'b000000, 0, 0), "rst_mid_ld");
    apply(mk(0, 1, 9, 0, 2'b01, 0, 0, 0, 1, 0, 6'b001111, 1, 0), "rst_mid_busy");
    apply(mk(1, 1, 9, 0, 2'b01, 0, 0, 0, 0, 0, 6'b000111, 1, 0), "rst_mid_rst");
    apply(mk(0, 1, 9, 0, 2'b01, 0, 0, 0, 0, 0, 6'b000000, 0, 0), "rst_mid_after");

`ifdef HAZARD_PERF_EN
    apply(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 6'b000000, 0, 0), "perf_rst");
    for (int r = 0; r < 3; r++) begin
      apply(mk(0, 1, 0, 0, 2'b00, 9, 1, 1, 0, 0, 6'b000000, 0, 0), $sformatf("perf_ld%0d", r));
      apply(mk(0, 1, 9, 0, 2'b01, 0, 0, 0, 0, 0, 6'b000111, 1, 0), $sformatf("perf_use%0d", r));
    end
    for (int b = 0; b < 4; b++) begin
      apply(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 6'b001111, 0, 0), $sformatf("perf_busy%0d", b));
    end
    apply(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 6'b000000, 0, 0), "perf_idle");
    chk_cnt("lu_stall_cnt", lu_stall_cnt, 32'd3);
    chk_cnt("busy_stall_cnt", busy_stall_cnt, 32'd4);
    apply(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 6'b000000, 0, 0), "perf_rst2");
    apply(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 6'b000000, 0, 0), "perf_idle2");
    chk_cnt("lu_stall_cnt_rst", lu_stall_cnt, 32'd0);
    chk_cnt("busy_stall_cnt_rst", busy_stall_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
